dmem_arbiter: RTL and testbench

Two-requester arbiter and access sequencer for the single-port data memory `d_mem`. It sits between the core's load/store stage (port 0) and the program loader/debug port (port 1), and grants the memory round-robin when both request. It drives `d_mem` with stable, one-cycle write/read strobes and returns registered read data with an ack pulse. It rejects out-of-range addresses without touching memory and keeps a saturating count of wait cycles.

---
 rtl/dmem_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and one-cycle access sequencer for the single-port data memory d_mem.
// Grants in IDLE only, strobes d_mem for exactly one ACCESS cycle, acks in RESP, counts wait cycles.
module dmem_arbiter #(
  parameter int unsigned MEM_WORDS = 256,
  parameter int unsigned STALL_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0,
  input  logic               req1,
  input  logic               we0,
  input  logic               we1,
  input  logic [31:0]        addr0,
  input  logic [31:0]        addr1,
  input  logic [31:0]        wdata0,
  input  logic [31:0]        wdata1,
  output logic               ack0,
  output logic               ack1,
  output logic               err0,
  output logic               err1,
  output logic [31:0]        rdata0,
  output logic [31:0]        rdata1,
  output logic [31:0]        mem_address,
  output logic [31:0]        mem_writeData,
  output logic               mem_memWrite,
  output logic               mem_memRead,
  input  logic [31:0]        mem_readData,
  output logic               busy,
  output logic [STALL_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic                 last_gnt_q, last_gnt_d;
  logic                 gnt_q, gnt_d;
  logic                 err_q, err_d;
  logic                 mem_write_q, mem_write_d;
  logic                 mem_read_q, mem_read_d;
  logic [31:0]          mem_address_q, mem_address_d;
  logic [31:0]          mem_wdata_q, mem_wdata_d;
  logic                 ack0_q, ack0_d;
  logic                 ack1_q, ack1_d;
  logic                 err0_q, err0_d;
  logic                 err1_q, err1_d;
  logic [31:0]          rdata0_q, rdata0_d;
  logic [31:0]          rdata1_q, rdata1_d;
  logic [STALL_W-1:0]   stall_q, stall_d;

  logic                 sel;
  logic                 sel_we;
  logic [31:0]          sel_addr;
  logic [31:0]          sel_wdata;
  logic                 sel_in_range;
  logic [1:0]           stall_inc;
  logic [STALL_W:0]     stall_sum;

  // Grant selection: a lone requester wins; on a conflict the port opposite last_gnt wins.
  always_comb begin
    if (req0 && req1) begin
      sel = ~last_gnt_q;
    end else begin
      sel = req1;
    end
    sel_we       = sel ? we1    : we0;
    sel_addr     = sel ? addr1  : addr0;
    sel_wdata    = sel ? wdata1 : wdata0;
    sel_in_range = (sel_addr < 32'(MEM_WORDS));
  end

  // A requester waits whenever it is not the port being granted (IDLE) or serviced (ACCESS/RESP).
  always_comb begin
    stall_inc = 2'd0;
    if (state_q == IDLE) begin
      stall_inc = (req0 && req1) ? 2'd1 : 2'd0;
    end else begin
      stall_inc = {1'b0, req0 && gnt_q} + {1'b0, req1 && !gnt_q};
    end
    stall_sum = {1'b0, stall_q} + {{(STALL_W-1){1'b0}}, stall_inc};
    stall_d   = stall_sum[STALL_W] ? {STALL_W{1'b1}} : stall_sum[STALL_W-1:0];
  end

  always_comb begin
    state_d       = state_q;
    last_gnt_d    = last_gnt_q;
    gnt_d         = gnt_q;
    err_d         = err_q;
    mem_address_d = mem_address_q;
    mem_wdata_d   = mem_wdata_q;
    rdata0_d      = rdata0_q;
    rdata1_d      = rdata1_q;
    mem_write_d   = 1'b0;
    mem_read_d    = 1'b0;
    ack0_d        = 1'b0;
    ack1_d        = 1'b0;
    err0_d        = 1'b0;
    err1_d        = 1'b0;

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d       = ACCESS;
          gnt_d         = sel;
          last_gnt_d    = sel;
          err_d         = !sel_in_range;
          mem_address_d = sel_addr;
          mem_wdata_d   = sel_wdata;
          // Strobes are registered so d_mem sees a clean single-cycle pulse in ACCESS.
          mem_write_d   = sel_we && sel_in_range;
          mem_read_d    = !sel_we && sel_in_range;
        end
      end
      ACCESS: begin
        state_d = RESP;
        if (mem_read_q) begin
          if (gnt_q) begin
            rdata1_d = mem_readData;
          end else begin
            rdata0_d = mem_readData;
          end
        end
        ack0_d = !gnt_q;
        ack1_d = gnt_q;
        err0_d = !gnt_q && err_q;
        err1_d = gnt_q && err_q;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      last_gnt_q    <= 1'b1;
      gnt_q         <= 1'b0;
      err_q         <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_address_q <= 32'd0;
      mem_wdata_q   <= 32'd0;
      ack0_q        <= 1'b0;
      ack1_q        <= 1'b0;
      err0_q        <= 1'b0;
      err1_q        <= 1'b0;
      rdata0_q      <= 32'd0;
      rdata1_q      <= 32'd0;
      stall_q       <= '0;
    end else begin
      state_q       <= state_d;
      last_gnt_q    <= last_gnt_d;
      gnt_q         <= gnt_d;
      err_q         <= err_d;
      mem_write_q   <= mem_write_d;
      mem_read_q    <= mem_read_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
      ack0_q        <= ack0_d;
      ack1_q        <= ack1_d;
      err0_q        <= err0_d;
      err1_q        <= err1_d;
      rdata0_q      <= rdata0_d;
      rdata1_q      <= rdata1_d;
      stall_q       <= stall_d;
    end
  end

  assign ack0          = ack0_q;
  assign ack1          = ack1_q;
  assign err0          = err0_q;
  assign err1          = err1_q;
  assign rdata0        = rdata0_q;
  assign rdata1        = rdata1_q;
  assign mem_address   = mem_address_q;
  assign mem_writeData = mem_wdata_q;
  assign mem_memWrite  = mem_write_q;
  assign mem_memRead   = mem_read_q;
  assign busy          = (state_q != IDLE);
  assign stall_count   = stall_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a behavioural d_mem, a scoreboard of expected acks,
// and a second instance with a 4-bit stall counter to observe saturation.
module tb_dmem_arbiter;

  localparam int W = 66; // {port, err, rdata[31:0], ack_cycle[31:0]}

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic        we0 = 1'b0, we1 = 1'b0;
  logic [31:0] addr0 = '0, addr1 = '0;
  logic [31:0] wdata0 = '0, wdata1 = '0;

  logic        ack0, ack1, err0, err1;
  logic [31:0] rdata0, rdata1;
  logic [31:0] mem_address, mem_writeData, mem_readData;
  logic        mem_memWrite, mem_memRead, busy;
  logic [15:0] stall_count;

  logic        s_ack0, s_ack1, s_err0, s_err1;
  logic [31:0] s_rdata0, s_rdata1, s_mem_address, s_mem_writeData;
  logic        s_mem_memWrite, s_mem_memRead, s_busy;
  logic [3:0]  s_stall_count;

  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  logic        pre_en = 1'b0;
  logic [7:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;

  logic [W-1:0] exp_q [$];
  logic [31:0]  exp_rd0 = '0, exp_rd1 = '0;
  int           cyc = 0;
  int           errors = 0;
  int           checks = 0;

  dmem_arbiter #(.MEM_WORDS(256), .STALL_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_address(mem_address), .mem_writeData(mem_writeData),
    .mem_memWrite(mem_memWrite), .mem_memRead(mem_memRead),
    .mem_readData(mem_readData), .busy(busy), .stall_count(stall_count)
  );

  dmem_arbiter #(.MEM_WORDS(256), .STALL_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(s_ack0), .ack1(s_ack1), .err0(s_err0), .err1(s_err1),
    .rdata0(s_rdata0), .rdata1(s_rdata1),
    .mem_address(s_mem_address), .mem_writeData(s_mem_writeData),
    .mem_memWrite(s_mem_memWrite), .mem_memRead(s_mem_memRead),
    .mem_readData(mem_readData), .busy(s_busy), .stall_count(s_stall_count)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // d_mem model: combinational read, level write sampled at the clock edge
  assign mem_readData = (mem_address < 32'd256) ? mem[mem_address[7:0]] : 32'hBAD0_BAD0;
  always @(posedge clk) begin
    if (pre_en) begin
      mem[pre_addr] <= pre_data;
    end else if (mem_memWrite && (mem_address < 32'd256)) begin
      mem[mem_address[7:0]] <= mem_writeData;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    pre_en   = 1'b1;
    pre_addr = a;
    pre_data = d;
    ref_mem[a] = d;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  // Issue one access at a negedge while the DUT is IDLE; returns at the negedge after RESP.
  task automatic do_txn(input logic port, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata);
    logic        in_r;
    logic [31:0] rd;
    in_r = (addr < 32'd256);
    if (port) begin
      req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata;
    end else begin
      req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata;
    end
    if (!we && in_r) begin
      if (port) exp_rd1 = ref_mem[addr[7:0]];
      else      exp_rd0 = ref_mem[addr[7:0]];
    end
    if (we && in_r) ref_mem[addr[7:0]] = wdata;
    rd = port ? exp_rd1 : exp_rd0;
    exp_q.push_back({port, !in_r, rd, 32'(cyc + 2)});
    @(negedge clk);
    check("access_memWrite", 32'(mem_memWrite), 32'(we && in_r));
    check("access_memRead", 32'(mem_memRead), 32'(!we && in_r));
    check("access_busy", 32'(busy), 32'd1);
    check("access_address", mem_address, addr);
    if (we) check("access_writeData", mem_writeData, wdata);
    @(negedge clk);
    check("resp_memWrite", 32'(mem_memWrite), 32'd0);
    check("resp_memRead", 32'(mem_memRead), 32'd0);
    check("resp_busy", 32'(busy), 32'd1);
    if (port) req1 = 1'b0;
    else      req0 = 1'b0;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  // Scoreboard monitor: every ack must match the head of the expected queue
  always @(negedge clk) begin : monitor
    logic [W-1:0] e;
    if (ack0 || ack1) begin
      check("ack_onehot", 32'(ack0 && ack1), 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: ack0=%b ack1=%b required no ack (t=%0t)", ack0, ack1, $time);
      end else begin
        e = exp_q.pop_front();
        check("ack_port", 32'(ack1), 32'(e[65]));
        check("ack_err", 32'(e[65] ? err1 : err0), 32'(e[64]));
        check("ack_rdata", e[65] ? rdata1 : rdata0, e[63:32]);
        check("ack_cycle", 32'(cyc), e[31:0]);
      end
    end
  end

  initial begin
    int c0;
    // Reset and preload
    preload(8'd0, 32'h0A0A_0A0A);
    preload(8'd5, 32'hDEAD_BEEF);
    preload(8'd255, 32'h0F0F_0F0F);
    check("rst_ack0", 32'(ack0), 32'd0);
    check("rst_ack1", 32'(ack1), 32'd0);
    check("rst_err", 32'({err0, err1}), 32'd0);
    check("rst_strobes", 32'({mem_memWrite, mem_memRead}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rdata0", rdata0, 32'd0);
    check("rst_rdata1", rdata1, 32'd0);
    check("rst_address", mem_address, 32'd0);
    check("rst_writeData", mem_writeData, 32'd0);
    check("rst_stall", 32'(stall_count), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single read, write/read on port 1, out-of-range writes, memory untouched
    do_txn(1'b0, 1'b0, 32'd5, 32'd0);
    do_txn(1'b1, 1'b1, 32'd10, 32'h1234_5678);
    do_txn(1'b1, 1'b0, 32'd10, 32'd0);
    do_txn(1'b0, 1'b1, 32'd256, 32'hCAFE_F00D);
    do_txn(1'b0, 1'b1, 32'hFFFF_FFFF, 32'h55AA_55AA);
    do_txn(1'b0, 1'b0, 32'd0, 32'd0);
    do_txn(1'b1, 1'b0, 32'd255, 32'd0);
    check("single_stall", 32'(stall_count), 32'd0);

    // Reset in the middle of a read access
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'd5;
    @(negedge clk);
    check("midrst_read_before", 32'(mem_memRead), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_read_drop", 32'(mem_memRead), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_rdata0", rdata0, 32'd0);
    req0 = 1'b0;
    exp_rd0 = '0;
    exp_rd1 = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_idle", 32'(busy), 32'd0);
    do_txn(1'b1, 1'b0, 32'd10, 32'd0);

    // Conflict from reset: grants 0,1,0,1,... one every 3 cycles, stall climbs by 1 each cycle
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_rd0 = '0;
    exp_rd1 = '0;
    @(negedge clk);
    c0 = cyc;
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'd5;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'd10;
    for (int k = 0; k < 7; k++) begin
      exp_q.push_back({k[0], 1'b0, (k[0] ? 32'h1234_5678 : 32'hDEAD_BEEF), 32'(c0 + 2 + 3 * k)});
    end
    for (int j = 0; j <= 20; j++) begin
      check("conflict_stall", 32'(stall_count), 32'(j));
      check("sat_stall", 32'(s_stall_count), 32'((j > 15) ? 15 : j));
      if (j == 20) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
      @(negedge clk);
    end
    check("stall_hold", 32'(stall_count), 32'd20);
    check("sat_hold", 32'(s_stall_count), 32'd15);
    repeat (3) @(negedge clk);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("mem0_unchanged", mem[0], ref_mem[0]);
    check("mem255_unchanged", mem[255], ref_mem[255]);
    check("mem10_written", mem[10], ref_mem[10]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
